// File: rtl/key_mgmt_pkg.sv
// Shared types for the key-load scheduler: FSM states, response status codes
// and the latched response header.
package key_mgmt_pkg;

  localparam int unsigned KEY_ID_W = 8;
  localparam int unsigned RSP_ID_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } key_sched_state_t;

  typedef enum logic [2:0] {
    RSP_OK      = 3'd0,
    RSP_INVALID = 3'd1,
    RSP_DENIED  = 3'd2,
    RSP_TIMEOUT = 3'd3,
    RSP_TAMPER  = 3'd4
  } key_rsp_status_t;

  typedef struct packed {
    logic [RSP_ID_W-1:0] req_id;
    key_rsp_status_t     status;
  } key_rsp_hdr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request searching upward
// from (last + 1) mod NUM_REQ. The last-served pointer is owned by the parent.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(last) + i) % NUM_REQ);
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_access_scheduler.sv
// Arbitrates key-load requests from the crypto engines onto the key store
// command port, enforcing the per-requester ACL, a load timeout and tamper abort.
module key_access_scheduler
  import key_mgmt_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned NUM_KEYS       = 32,
  parameter int unsigned KEY_WIDTH      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0][KEY_ID_W-1:0]   req_key_id,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0][NUM_KEYS-1:0]   acl_mask,
  output logic                               ks_start,
  output logic [KEY_ID_W-1:0]                ks_key_id,
  input  logic                               ks_done,
  input  logic                               ks_key_valid,
  input  logic [KEY_WIDTH-1:0]               ks_key_data,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [RSP_ID_W-1:0]                rsp_req_id,
  output logic [KEY_WIDTH-1:0]               rsp_key,
  output logic [2:0]                         rsp_status,
  output logic                               busy,
  input  logic                               tamper_detect
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned KIX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  key_sched_state_t     state_q, state_d;
  logic [IDX_W-1:0]     last_q;
  logic [CNT_W-1:0]     cnt_q, cnt_inc;
  logic [KEY_WIDTH-1:0] key_q;
  key_rsp_hdr_t         hdr_q;
  logic                 ks_start_q, rsp_valid_q, busy_q;
  logic [KEY_ID_W-1:0]  ks_key_id_q;

  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_any;
  logic [KEY_ID_W-1:0]  sel_id;
  logic                 id_ok;
  logic                 accept;
  logic                 timeout_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req_valid),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Slot must exist and be enabled for the granted requester.
  assign sel_id      = req_key_id[grant_idx];
  assign id_ok       = (32'(sel_id) < NUM_KEYS) && acl_mask[grant_idx][sel_id[KIX_W-1:0]];
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!tamper_detect && grant_any) begin
          req_ready = grant;
          accept    = 1'b1;
          state_d   = id_ok ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: state_d = tamper_detect ? ST_RESP : ST_WAIT;
      ST_WAIT: begin
        if (tamper_detect || ks_done || timeout_hit) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      ks_start_q  <= 1'b0;
      ks_key_id_q <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ks_start_q  <= (state_d == ST_ISSUE);
      ks_key_id_q <= (accept && id_ok) ? sel_id : '0;
      rsp_valid_q <= (state_d == ST_RESP);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  // Counter is cleared at accept and runs through ISSUE, so it counts cycles
  // since ks_start and the timeout response lands TIMEOUT_CYCLES after it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= IDX_W'(NUM_REQ - 1);
      cnt_q  <= '0;
      key_q  <= '0;
      hdr_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            hdr_q.req_id <= RSP_ID_W'(grant_idx);
            hdr_q.status <= id_ok ? RSP_OK : RSP_DENIED;
            cnt_q        <= '0;
            key_q        <= '0;
          end
        end
        ST_ISSUE: begin
          cnt_q <= cnt_inc;
          if (tamper_detect) hdr_q.status <= RSP_TAMPER;
        end
        ST_WAIT: begin
          cnt_q <= cnt_inc;
          if (tamper_detect) begin
            hdr_q.status <= RSP_TAMPER;
            key_q        <= '0;
          end else if (ks_done) begin
            hdr_q.status <= ks_key_valid ? RSP_OK : RSP_INVALID;
            key_q        <= ks_key_valid ? ks_key_data : '0;
          end else if (timeout_hit) begin
            hdr_q.status <= RSP_TIMEOUT;
            key_q        <= '0;
          end
        end
        ST_RESP: begin
          if (tamper_detect) hdr_q.status <= RSP_TAMPER;
          if (tamper_detect || rsp_ready) key_q <= '0;
          if (rsp_ready) last_q <= IDX_W'(hdr_q.req_id);
        end
        default: key_q <= '0;
      endcase
    end
  end

  assign ks_start   = ks_start_q;
  assign ks_key_id  = ks_key_id_q;
  assign rsp_valid  = rsp_valid_q;
  assign busy       = busy_q;
  assign rsp_req_id = hdr_q.req_id;
  // Tamper hides the key and overrides the status without waiting for a clock edge.
  assign rsp_key    = tamper_detect ? '0 : key_q;
  assign rsp_status = (tamper_detect && state_q == ST_RESP) ? 3'(RSP_TAMPER) : 3'(hdr_q.status);

endmodule

// File: tb/tb_key_access_scheduler.sv
// Scoreboard bench for key_access_scheduler: directed requests push expected
// responses; a monitor pops and checks them at each response handshake.
module tb_key_access_scheduler;
  import key_mgmt_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned NK = 32;
  localparam int unsigned KW = 256;
  localparam int unsigned TO = 64;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0][7:0]   req_key_id;
  logic [NR-1:0]        req_ready;
  logic [NR-1:0][NK-1:0] acl_mask;
  logic                 ks_start;
  logic [7:0]           ks_key_id;
  logic                 ks_done;
  logic                 ks_key_valid;
  logic [KW-1:0]        ks_key_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [2:0]           rsp_req_id;
  logic [KW-1:0]        rsp_key;
  logic [2:0]           rsp_status;
  logic                 busy;
  logic                 tamper_detect;

  always #5 clk = ~clk;

  key_access_scheduler #(
    .NUM_REQ(NR), .NUM_KEYS(NK), .KEY_WIDTH(KW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_key_id(req_key_id),
    .req_ready(req_ready), .acl_mask(acl_mask), .ks_start(ks_start),
    .ks_key_id(ks_key_id), .ks_done(ks_done), .ks_key_valid(ks_key_valid),
    .ks_key_data(ks_key_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_req_id(rsp_req_id), .rsp_key(rsp_key), .rsp_status(rsp_status),
    .busy(busy), .tamper_detect(tamper_detect)
  );

  typedef struct {
    logic [2:0]    id;
    logic [2:0]    st;
    logic [KW-1:0] key;
    int            lat;
  } exp_t;

  exp_t          exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            last_acc_cyc = 0;
  logic [7:0]    last_acc_id = '0;
  int            n_starts = 0;
  int            ks_delay = -1;
  logic          ks_valid_cfg = 1'b1;
  logic [KW-1:0] ks_data_cfg = '0;
  int            late_req = 0;
  int            late_seen = 0;
  logic [KW-1:0] key_a5 = {32{8'hA5}};
  logic [KW-1:0] key_3c = {32{8'h3C}};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accept observer: one-hot ready, records accept cycle and requested slot.
  always @(negedge clk) begin
    if (rstn && (req_ready != '0)) begin
      chk("ready_onehot", KW'($onehot(req_ready)), KW'(1));
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i]) begin
          last_acc_cyc = cyc;
          last_acc_id  = req_key_id[i];
          chk("ready_has_valid", KW'(req_valid[i]), KW'(1));
        end
      end
    end
  end

  // Key store model: answers ks_start after ks_delay cycles (never if < 1).
  initial begin
    ks_done = 1'b0; ks_key_valid = 1'b0; ks_key_data = '0;
    forever begin
      @(negedge clk);
      if (rstn && ks_start) begin
        n_starts++;
        chk("ks_start_lat", KW'(cyc - last_acc_cyc), KW'(1));
        chk("ks_key_id", KW'(ks_key_id), KW'(last_acc_id));
        if (ks_delay > 0) begin
          repeat (ks_delay) @(negedge clk);
          ks_done = 1'b1; ks_key_valid = ks_valid_cfg; ks_key_data = ks_data_cfg;
          @(negedge clk);
          ks_done = 1'b0; ks_key_valid = 1'b0; ks_key_data = '0;
        end
      end else if (late_req != late_seen) begin
        late_seen = late_req;
        ks_done = 1'b1; ks_key_valid = 1'b1; ks_key_data = key_a5;
        @(negedge clk);
        ks_done = 1'b0; ks_key_valid = 1'b0; ks_key_data = '0;
      end
    end
  end

  // Response monitor.
  logic prev_v = 1'b0;
  int   v_start = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      prev_v = 1'b0;
    end else begin
      if (rsp_valid && !prev_v) v_start = cyc;
      prev_v = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", KW'(1), KW'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rsp_req_id", KW'(rsp_req_id), KW'(e.id));
          chk("rsp_status", KW'(rsp_status), KW'(e.st));
          chk("rsp_key", rsp_key, e.key);
          chk("rsp_latency", KW'(v_start - last_acc_cyc), KW'(e.lat));
        end
      end
    end
  end

  task automatic issue(input int r, input logic [7:0] id, input bit push,
                       input logic [2:0] st, input logic [KW-1:0] key, input int lat);
    bit got = 1'b0;
    @(posedge clk); #1;
    if (push) exp_q.push_back('{3'(r), st, key, lat});
    req_key_id[r] = id;
    req_valid[r]  = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready[r]) begin got = 1'b1; break; end
    end
    chk("accept_seen", KW'(got), KW'(1));
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) begin got = 1'b1; break; end
    end
    chk("idle_reached", KW'(got), KW'(1));
  endtask

  task automatic wait_rsp();
    bit got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; break; end
    end
    chk("rsp_valid_seen", KW'(got), KW'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"},  KW'(req_ready),  '0);
    chk({tag, "_ks_start"},   KW'(ks_start),   '0);
    chk({tag, "_ks_key_id"},  KW'(ks_key_id),  '0);
    chk({tag, "_rsp_valid"},  KW'(rsp_valid),  '0);
    chk({tag, "_rsp_req_id"}, KW'(rsp_req_id), '0);
    chk({tag, "_rsp_key"},    rsp_key,         '0);
    chk({tag, "_rsp_status"}, KW'(rsp_status), '0);
    chk({tag, "_busy"},       KW'(busy),       '0);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [KW-1:0] snap_key;
    logic [5:0]    snap_hdr;
    int            s0;

    rstn = 1'b0; req_valid = '0; req_key_id = '0; rsp_ready = 1'b1; tamper_detect = 1'b0;
    acl_mask = '1;
    acl_mask[2][7] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rstn = 1'b1;

    // Fairness: all requesters held high, grants 0,1,2,3,0.
    ks_delay = 1; ks_valid_cfg = 1'b1; ks_data_cfg = key_3c;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) exp_q.push_back('{3'(i % 4), 3'(RSP_OK), key_3c, 3});
    for (int r = 0; r < NR; r++) req_key_id[r] = 8'(10 + r);
    req_valid = '1;
    for (int a = 0; a < 5; a++) begin
      bit got = 1'b0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (req_ready != '0) begin got = 1'b1; break; end
      end
      chk("fair_accept", KW'(got), KW'(1));
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // Single request, key store answers 3 cycles after ks_start.
    ks_delay = 3; ks_data_cfg = key_a5;
    issue(0, 8'd5, 1'b1, 3'(RSP_OK), key_a5, 5);
    wait_idle();

    // Access denied by ACL, then out-of-range slot; key store untouched.
    s0 = n_starts;
    issue(2, 8'd7, 1'b1, 3'(RSP_DENIED), '0, 1);
    wait_idle();
    issue(2, 8'd40, 1'b1, 3'(RSP_DENIED), '0, 1);
    wait_idle();
    chk("denied_no_ks_start", KW'(n_starts), KW'(s0));

    // Invalid slot with 10 cycles of backpressure.
    ks_delay = 2; ks_valid_cfg = 1'b0; ks_data_cfg = '1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(1, 8'd9, 1'b1, 3'(RSP_INVALID), '0, 4);
    wait_rsp();
    snap_key = rsp_key;
    snap_hdr = {rsp_req_id, rsp_status};
    chk("invalid_key_zero", snap_key, '0);
    @(posedge clk); #1;
    req_key_id[3] = 8'd2;
    req_valid[3]  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold_hdr", KW'({rsp_req_id, rsp_status}), KW'(snap_hdr));
      chk("bp_hold_key", rsp_key, snap_key);
      chk("bp_no_accept", KW'(req_ready), '0);
    end
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();

    // Timeout, then a late ks_done while the response is held.
    ks_delay = -1; ks_valid_cfg = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    issue(0, 8'd1, 1'b1, 3'(RSP_TIMEOUT), '0, TO + 1);
    wait_rsp();
    @(posedge clk); #1;
    late_req++;
    repeat (2) @(negedge clk);
    chk("late_done_status", KW'(rsp_status), KW'(RSP_TIMEOUT));
    chk("late_done_key", rsp_key, '0);
    chk("late_done_valid", KW'(rsp_valid), KW'(1));
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_idle();

    // Tamper in WAIT aborts; held tamper blocks grants in IDLE.
    issue(1, 8'd3, 1'b1, 3'(RSP_TAMPER), '0, 3);
    @(posedge clk); #1;
    tamper_detect = 1'b1;
    wait_idle();
    @(posedge clk); #1;
    req_key_id[0] = 8'd4;
    req_valid[0]  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("tamper_no_ready", KW'(req_ready), '0);
      chk("tamper_not_busy", KW'(busy), '0);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    tamper_detect = 1'b0;
    @(negedge clk);
    chk("scoreboard_drained", KW'(exp_q.size()), '0);

    // Reset in WAIT; the key store's pending ks_done lands after reset.
    ks_delay = 10; ks_data_cfg = key_a5;
    issue(2, 8'd4, 1'b0, 3'(RSP_OK), key_a5, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    exp_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk("post_reset_no_rsp", KW'(rsp_valid), '0);
      chk("post_reset_idle", KW'(busy), '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
